// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, issue logic and the register-file write arbiter.
// The slave modport is the arbiter; the master modport is the requester/issue side.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*5-1:0]  req_sel_i;
  logic [NUM_REQ*32-1:0] req_data_i;
  logic                  rf_hold_i;
  logic [31:0]           rf_in_o;
  logic [4:0]            rf_in_sel_o;
  logic                  rf_in_en_o;
  logic                  alloc_valid_i;
  logic [4:0]            alloc_sel_i;
  logic [31:0]           busy_o;

  modport slave (
    input  req_valid_i, req_sel_i, req_data_i, rf_hold_i, alloc_valid_i, alloc_sel_i,
    output req_ready_o, rf_in_o, rf_in_sel_o, rf_in_en_o, busy_o
  );

  modport master (
    output req_valid_i, req_sel_i, req_data_i, rf_hold_i, alloc_valid_i, alloc_sel_i,
    input  req_ready_o, rf_in_o, rf_in_sel_o, rf_in_en_o, busy_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Define REGFILE_WB_ARB_SCOREBOARD_EN to track in-flight destination registers on busy_o.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                clk,
  input  logic                reset_i,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      r_rr_ptr;
  logic               r_out_valid;
  logic [4:0]         r_out_sel;
  logic [31:0]        r_out_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_grant_idx;
  logic               w_grant_any;
  logic               w_accept_ok;
  logic               w_xfer;
  logic [PW-1:0]      w_next_ptr;
  logic               w_rf_en;
  logic [4:0]         w_sel  [NUM_REQ];
  logic [31:0]        w_data [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_sel[gi]  = bus.req_sel_i[5*gi +: 5];
      assign w_data[gi] = bus.req_data_i[32*gi +: 32];
    end
  endgenerate

  // Scan from the round-robin pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    logic [PW:0] cand;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!w_grant_any && bus.req_valid_i[cand[PW-1:0]]) begin
        w_grant_any             = 1'b1;
        w_grant_idx             = cand[PW-1:0];
        w_grant[cand[PW-1:0]]   = 1'b1;
      end
    end
  end

  assign w_accept_ok     = ~bus.rf_hold_i & ~reset_i;
  assign bus.req_ready_o = w_grant & {NUM_REQ{w_accept_ok}};
  assign w_xfer          = w_grant_any & w_accept_ok;
  assign w_next_ptr      = (w_grant_idx == PW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // While the port is held externally the out stage freezes, so nothing is lost or repeated.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_rr_ptr    <= w_next_ptr;
      r_out_sel   <= w_sel[w_grant_idx];
      r_out_data  <= w_data[w_grant_idx];
      r_out_valid <= (w_sel[w_grant_idx] != 5'd0);
    end else if (!bus.rf_hold_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign w_rf_en         = r_out_valid & ~bus.rf_hold_i;
  assign bus.rf_in_en_o  = w_rf_en;
  assign bus.rf_in_sel_o = r_out_sel;
  assign bus.rf_in_o     = r_out_data;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_busy_next;

  // Set is applied after clear so a fresh allocation outranks the retiring write.
  always_comb begin
    w_busy_next = r_busy;
    if (w_rf_en) begin
      w_busy_next[r_out_sel] = 1'b0;
    end
    if (bus.alloc_valid_i && (bus.alloc_sel_i != 5'd0)) begin
      w_busy_next[bus.alloc_sel_i] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign bus.busy_o = r_busy;
`else
  logic w_alloc_unused;
  assign w_alloc_unused = ^{bus.alloc_valid_i, bus.alloc_sel_i};
  assign bus.busy_o     = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter: a cycle-level reference model
// pushes expected outputs, an independent monitor pops and compares them each cycle.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  typedef struct {
    logic [NR-1:0] ready;
    logic          en;
    logic [4:0]    sel;
    logic [31:0]   data;
    logic [31:0]   busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();
  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (.clk(clk), .reset_i(reset_i), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  exp_t exp_q[$];

  // requester-side pending items
  bit          rq_v    [NR];
  logic [4:0]  rq_sel  [NR];
  logic [31:0] rq_data [NR];

  // reference model state
  int          m_ptr;
  bit          m_pv;
  logic [4:0]  m_ps;
  logic [31:0] m_pd;
  logic [31:0] m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pv = 1'b0; m_ps = '0; m_pd = '0; m_busy = '0;
    for (int i = 0; i < NR; i++) rq_v[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] s, input logic [31:0] d);
    rq_v[i] = 1'b1; rq_sel[i] = s; rq_data[i] = d;
  endtask

  // Called just after a rising edge: drive one cycle, predict it, advance to the next edge.
  task automatic apply(input bit hold, input bit alloc, input logic [4:0] asel);
    exp_t e;
    int g;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid_i[i]        = rq_v[i];
      bus.req_sel_i[5*i +: 5]   = rq_sel[i];
      bus.req_data_i[32*i +: 32] = rq_data[i];
    end
    bus.rf_hold_i     = hold;
    bus.alloc_valid_i = alloc;
    bus.alloc_sel_i   = asel;

    e.en   = m_pv && !hold;
    e.sel  = m_ps;
    e.data = m_pd;
    e.busy = SB_ON ? m_busy : 32'd0;
    g = -1;
    if (!hold) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && rq_v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    e.ready = '0;
    if (g >= 0) e.ready[g] = 1'b1;
    exp_q.push_back(e);

    if (e.en) m_busy[m_ps] = 1'b0;
    if (alloc && asel != 5'd0) m_busy[asel] = 1'b1;
    if (g >= 0) begin
      m_ptr = (g + 1) % NR;
      m_pv  = (rq_sel[g] != 5'd0);
      m_ps  = rq_sel[g];
      m_pd  = rq_data[g];
      rq_v[g] = 1'b0;
    end else if (!hold) begin
      m_pv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: one expectation per cycle, compared away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("exp_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ready", 32'(bus.req_ready_o), 32'(e.ready));
          chk("rf_en", 32'(bus.rf_in_en_o), 32'(e.en));
          chk("busy", bus.busy_o, e.busy);
          if (e.en) begin
            chk("rf_sel", 32'(bus.rf_in_sel_o), 32'(e.sel));
            chk("rf_data", bus.rf_in_o, e.data);
            $display("write x%0d = %h", bus.rf_in_sel_o, bus.rf_in_o);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < NR; i++) begin rq_sel[i] = '0; rq_data[i] = '0; end
    bus.req_valid_i = '1; bus.req_sel_i = '1; bus.req_data_i = '1;
    bus.rf_hold_i = 1'b0; bus.alloc_valid_i = 1'b1; bus.alloc_sel_i = 5'd9;

    // reset state with every requester asking
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_en", 32'(bus.rf_in_en_o), 32'd0);
    chk("rst_sel", 32'(bus.rf_in_sel_o), 32'd0);
    chk("rst_data", bus.rf_in_o, 32'd0);
    chk("rst_busy", bus.busy_o, 32'd0);
    bus.req_valid_i = '0; bus.alloc_valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // round robin 0,1,2,0
    set_req(0, 5'd5, 32'hAAAA_0001);
    set_req(1, 5'd6, 32'hBBBB_0002);
    set_req(2, 5'd7, 32'hCCCC_0003);
    apply(0, 0, 0);
    set_req(0, 5'd8, 32'hDDDD_0004);
    apply(0, 0, 0);
    apply(0, 0, 0);
    apply(0, 0, 0);
    apply(0, 0, 0);

    // x0 request is accepted but never written; pointer moves past it
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    apply(0, 0, 0);
    apply(0, 0, 0);
    set_req(0, 5'd1, 32'h0000_0011);
    set_req(1, 5'd2, 32'h0000_0022);
    apply(0, 0, 0);
    apply(0, 0, 0);
    apply(0, 0, 0);

    // hold three cycles with a write pending and another requester waiting
    set_req(2, 5'd3, 32'h0000_1234);
    apply(0, 0, 0);
    set_req(0, 5'd4, 32'h0000_5678);
    apply(1, 0, 0);
    apply(1, 0, 0);
    apply(1, 0, 0);
    apply(0, 0, 0);
    apply(0, 0, 0);
    apply(0, 0, 0);

    // busy tracking: alloc, write, and alloc colliding with commit
    apply(0, 1, 5'd9);
    set_req(1, 5'd9, 32'h0909_0909);
    apply(0, 0, 0);
    apply(0, 0, 0);
    apply(0, 1, 5'd9);
    set_req(1, 5'd9, 32'h0909_1111);
    apply(0, 0, 0);
    apply(0, 1, 5'd9);
    apply(0, 0, 0);
    apply(0, 1, 5'd0);
    apply(0, 0, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rq_v[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        end
      end
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
    end
    for (int c = 0; c < 8; c++) apply(0, 0, 0);

    // reset mid-operation discards the pending write
    set_req(0, 5'd12, 32'hDEAD_BEEF);
    set_req(1, 5'd13, 32'hCAFE_F00D);
    apply(0, 1, 5'd14);
    mon_en = 1'b0;
    bus.req_valid_i = '1;
    bus.alloc_valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_en", 32'(bus.rf_in_en_o), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("mid_rst_sel", 32'(bus.rf_in_sel_o), 32'd0);
    chk("mid_rst_data", bus.rf_in_o, 32'd0);
    chk("mid_rst_busy", bus.busy_o, 32'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_en", 32'(bus.rf_in_en_o), 32'd0);
    chk("post_rst_busy", bus.busy_o, 32'd0);
    if (exp_q.size() != 0) chk("exp_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
